car_sensor_cond: RTL and testbench

Conditions the raw farm-road car-detector input and produces the clean, latched car-request `c` consumed by the traffic-light FSM.
- Synchronises the asynchronous sensor and debounces it.
- Latches a short-lived car detection until the farm road is served (FL shows green), so a passing car always gets its green.
- Runs on the undivided 125 MHz clock, upstream of the FSM.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/sync_debounce.sv | 49 ++++
 rtl/car_sensor_cond.sv | 94 +++++++++
 tb/tb_car_sensor_cond.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic-light controller and its input
// conditioning logic.
package traffic_pkg;

   // Farm/highway light encodings, one-hot {R,Y,G}.
   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   // Car-request tracking states.
   //   IDLE    : no outstanding request
   //   PENDING : a car was detected and has not yet been given green
   //   SERVING : farm road is green, new detections need no latching
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SERVING = 2'd2
   } req_state_t;

endpackage

// File: rtl/sync_debounce.sv
// 2-FF synchroniser followed by a stable-level debouncer. The output only
// changes after the synchronised input has differed from it for DEB_CYCLES
// consecutive clocks; any bounce back restarts the count.
module sync_debounce #(
   parameter int DEB_CYCLES = 1250000
) (
   input  logic clk_125M,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             s_sync;
   logic [CNT_W-1:0] cnt;
   logic             deb_state;

   // Two-stage synchroniser for the asynchronous input.
   always_ff @(posedge clk_125M) begin
      if (!rst) begin
         sync1  <= 1'b0;
         s_sync <= 1'b0;
      end else begin
         sync1  <= din;
         s_sync <= sync1;
      end
   end

   // Stable counter: accept a new level once it has been held long enough.
   always_ff @(posedge clk_125M) begin
      if (!rst) begin
         cnt       <= '0;
         deb_state <= 1'b0;
      end else if (s_sync == deb_state) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         deb_state <= s_sync;
         cnt       <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign dout = deb_state;

endmodule

// File: rtl/car_sensor_cond.sv
// Farm-road car sensor conditioning: debounces the raw detector, latches a
// detection until the farm road has been given green, and counts requests.
// FL arrives from the divided-clock domain and is re-synchronised here.
module car_sensor_cond
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = 1250000,
   parameter int CNT_SAT    = 255
) (
   input  logic       clk_125M,
   input  logic       rst,
   input  logic       sensor_raw,
   input  logic [2:0] FL,
   output logic       c,
   output logic [7:0] req_cnt
);

   logic       deb_state;
   logic       deb_prev;
   logic       deb_rise;
   logic [2:0] fl_s1;
   logic [2:0] fl_s2;
   logic       fl_green_s;
   logic       count_req;

   req_state_t state;
   req_state_t state_next;

   sync_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk_125M (clk_125M),
      .rst      (rst),
      .din      (sensor_raw),
      .dout     (deb_state)
   );

   // Synchronise each FL bit and remember the previous debounced level.
   always_ff @(posedge clk_125M) begin
      if (!rst) begin
         fl_s1    <= 3'b000;
         fl_s2    <= 3'b000;
         deb_prev <= 1'b0;
      end else begin
         fl_s1    <= FL;
         fl_s2    <= fl_s1;
         deb_prev <= deb_state;
      end
   end

   // Only an exact green code counts; illegal multi-hot values do not.
   assign fl_green_s = (fl_s2 == LT_GRN);
   assign deb_rise   = deb_state & ~deb_prev;

   // Next-state and request-count decision for the request tracker.
   always_comb begin
      state_next = state;
      count_req  = 1'b0;
      case (state)
         IDLE: begin
            if (fl_green_s) begin
               state_next = SERVING;
               count_req  = deb_rise;
            end else if (deb_rise) begin
               state_next = PENDING;
               count_req  = 1'b1;
            end
         end
         PENDING: begin
            if (fl_green_s) state_next = SERVING;
         end
         SERVING: begin
            if (!fl_green_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register, registered car request and saturating request counter.
   always_ff @(posedge clk_125M) begin
      if (!rst) begin
         state   <= IDLE;
         c       <= 1'b0;
         req_cnt <= 8'd0;
      end else begin
         state <= state_next;
         c     <= deb_state | (state == PENDING);
         if (count_req && (req_cnt != 8'(CNT_SAT))) begin
            req_cnt <= req_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_car_sensor_cond.sv
// Testbench for car_sensor_cond with a short debounce window. A behavioural
// model tracks the sensor as a history of synchronised samples and the
// request as pending/serving flags; outputs are compared every cycle.
module tb_car_sensor_cond;
   import traffic_pkg::*;

   localparam int DEB = 4;
   localparam int SAT = 255;

   // ---------------- clock / reset ----------------
   logic       clk_125M = 1'b0;
   logic       rst;
   logic       sensor_raw;
   logic [2:0] FL;
   logic       c;
   logic [7:0] req_cnt;

   always #4 clk_125M = ~clk_125M;

   car_sensor_cond #(
      .DEB_CYCLES (DEB),
      .CNT_SAT    (SAT)
   ) dut (
      .clk_125M   (clk_125M),
      .rst        (rst),
      .sensor_raw (sensor_raw),
      .FL         (FL),
      .c          (c),
      .req_cnt    (req_cnt)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic       raw_q[$];   // raw samples still inside the synchroniser
   logic [2:0] fl_q[$];    // FL samples still inside the synchroniser
   logic       s_hist[$];  // last DEB synchronised sensor values
   logic       m_deb, m_prev, m_pending, m_serving, m_c;
   int         m_cnt;

   task automatic model_reset();
      raw_q = '{1'b0, 1'b0};
      fl_q  = '{3'b000, 3'b000};
      s_hist.delete();
      m_deb = 1'b0; m_prev = 1'b0; m_pending = 1'b0; m_serving = 1'b0;
      m_c = 1'b0; m_cnt = 0;
   endtask

   task automatic count_one();
      if (m_cnt < SAT) m_cnt++;
   endtask

   // One clock edge of the reference behaviour, using pre-edge values.
   task automatic model_update();
      logic s, green, rise, new_c, flip;
      if (!rst) begin
         model_reset();
         return;
      end
      s = raw_q.pop_front();
      raw_q.push_back(sensor_raw);
      green = (fl_q.pop_front() == LT_GRN);
      fl_q.push_back(FL);
      rise  = m_deb && !m_prev;
      new_c = m_deb || m_pending;
      // Accept a new level once the last DEB samples all disagree with it.
      s_hist.push_back(s);
      if (s_hist.size() > DEB) void'(s_hist.pop_front());
      flip = (s_hist.size() == DEB);
      foreach (s_hist[i]) if (s_hist[i] == m_deb) flip = 1'b0;
      m_prev = m_deb;
      if (flip) m_deb = !m_deb;
      // Request tracking.
      if (m_serving) begin
         if (!green) m_serving = 1'b0;
      end else if (green) begin
         if (!m_pending && rise) count_one();
         m_pending = 1'b0;
         m_serving = 1'b1;
      end else if (!m_pending && rise) begin
         m_pending = 1'b1;
         count_one();
      end
      m_c = new_c;
   endtask

   // ---------------- driver tasks ----------------
   // Advance one edge, update the model and compare on the falling edge.
   task automatic step();
      @(posedge clk_125M);
      model_update();
      @(negedge clk_125M);
      check("c", 32'(c), 32'(m_c));
      check("req_cnt", 32'(req_cnt), 32'(m_cnt));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b0;
      steps(n);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic seen_c;
      rst = 1'b0; sensor_raw = 1'b1; FL = LT_RED;
      model_reset();

      // 1. Reset with sensor held, then release.
      for (int i = 0; i < 3; i++) begin
         step();
         check("t1_rst_c", 32'(c), 32'd0);
         check("t1_rst_cnt", 32'(req_cnt), 32'd0);
      end
      rst = 1'b1;
      steps(6);
      check("t1_c_edge6", 32'(c), 32'd0);
      step();
      check("t1_c_edge7", 32'(c), 32'd1);
      check("t1_cnt", 32'(req_cnt), 32'd1);

      // 2. Glitch rejection.
      sensor_raw = 1'b0; FL = LT_RED;
      apply_reset(2);
      seen_c = 1'b0;
      for (int r = 0; r < 5; r++) begin
         sensor_raw = 1'b1;
         for (int i = 0; i < 3; i++) begin step(); seen_c |= c; end
         sensor_raw = 1'b0;
         for (int i = 0; i < 4; i++) begin step(); seen_c |= c; end
      end
      steps(4);
      check("t2_c_never", 32'(seen_c), 32'd0);
      check("t2_cnt", 32'(req_cnt), 32'd0);

      // 3. Short car latched until farm green.
      sensor_raw = 1'b1;
      steps(10);
      sensor_raw = 1'b0;
      steps(20);
      check("t3_c_latched", 32'(c), 32'd1);
      check("t3_cnt", 32'(req_cnt), 32'd1);
      FL = LT_GRN;
      steps(4);
      check("t3_c_served", 32'(c), 32'd0);
      check("t3_state", 32'(dut.state), 32'(SERVING));

      // 4. Car held through green, then leaving.
      sensor_raw = 1'b1;
      steps(12);
      check("t4_c_held", 32'(c), 32'd1);
      sensor_raw = 1'b0;
      steps(6);
      check("t4_c_edge6", 32'(c), 32'd1);
      step();
      check("t4_c_edge7", 32'(c), 32'd0);
      FL = LT_RED;
      steps(4);
      check("t4_state", 32'(dut.state), 32'(IDLE));
      check("t4_cnt", 32'(req_cnt), 32'd1);

      // 5. Rise during SERVING is neither latched nor counted.
      FL = LT_GRN;
      steps(4);
      sensor_raw = 1'b1;
      steps(10);
      sensor_raw = 1'b0;
      steps(12);
      check("t5_cnt", 32'(req_cnt), 32'd1);
      FL = LT_RED;
      steps(4);
      check("t5_c", 32'(c), 32'd0);
      check("t5_state", 32'(dut.state), 32'(IDLE));

      // 6. Saturation, then reset in the middle of a debounce.
      for (int r = 0; r < 300; r++) begin
         sensor_raw = 1'b1; steps(8);
         sensor_raw = 1'b0; steps(8);
         FL = LT_GRN;       steps(4);
         FL = LT_RED;       steps(4);
      end
      check("t6_sat", 32'(req_cnt), 32'd255);
      sensor_raw = 1'b1;
      steps(4);
      check("t6_deb_cnt", 32'(dut.u_deb.cnt), 32'd2);
      rst = 1'b0;
      step();
      check("t6_rst_cnt", 32'(req_cnt), 32'd0);
      check("t6_rst_c", 32'(c), 32'd0);
      rst = 1'b1;

      // Random phase: sensor/FL segments including illegal FL codes and
      // occasional resets.
      for (int seg = 0; seg < 300; seg++) begin
         sensor_raw = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0, 1:    FL = LT_GRN;
            2:       FL = LT_RED;
            3:       FL = LT_YEL;
            4:       FL = 3'b011;
            default: FL = 3'b101;
         endcase
         rst = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
         steps($urandom_range(1, 9));
         rst = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
